// File: rtl/conv5x5_bin.sv
// 5x5 binary-weight convolution over a streamed column-per-word image, with sign activation.
// Three-stage pipeline: window shift, registered row sums, final sum and activation.
module conv5x5_bin #(
  parameter int DW = 16,
  parameter int AW = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 state,
  input  logic [5*DW-1:0]      taps,
  input  logic [24:0]          weight,
  output logic signed [AW-1:0] sum_out,
  output logic                 bin_out,
  output logic                 out_valid,
  output logic                 done
);

  localparam int RW = DW + 3;

  localparam logic [9:0] LAST_K_28 = 10'd671;
  localparam logic [9:0] LAST_K_12 = 10'd95;
  localparam logic [4:0] LAST_X_28 = 5'd27;
  localparam logic [4:0] LAST_X_12 = 5'd11;

  logic [9:0]           r_k;
  logic [4:0]           r_x;
  logic                 r_mode;
  logic [24:0]          r_weight;
  logic signed [DW-1:0] r_win [5][5];
  logic                 r_v1;
  logic                 r_last1;
  logic                 r_v2;
  logic                 r_last2;
  logic signed [RW-1:0] r_row [5];

  logic                 w_first;
  logic                 w_mode;
  logic                 w_last_k;
  logic [4:0]           w_last_x;
  logic signed [RW-1:0] w_row_sum [5];
  logic signed [AW-1:0] w_total;

  function automatic logic signed [RW-1:0] f_term(input logic signed [DW-1:0] p,
                                                  input logic w);
    logic signed [RW-1:0] e;
    e = {{(RW-DW){p[DW-1]}}, p};
    return w ? e : -e;
  endfunction

  // The first word of a frame already runs under the mode it is about to latch.
  assign w_first  = (r_k == 10'd0);
  assign w_mode   = w_first ? state : r_mode;
  assign w_last_k = (r_k == (w_mode ? LAST_K_12 : LAST_K_28));
  assign w_last_x = w_mode ? LAST_X_12 : LAST_X_28;

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    for (int r = 0; r < 5; r++) begin
      w_row_sum[r] = '0;
      for (int c = 0; c < 5; c++) begin
        w_row_sum[r] = w_row_sum[r] + f_term(r_win[r][c], r_weight[r*5+c]);
      end
    end
  end

  always_comb begin
    w_total = '0;
    for (int r = 0; r < 5; r++) begin
      w_total = w_total + {{(AW-RW){r_row[r][RW-1]}}, r_row[r]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_x      <= '0;
      r_mode   <= 1'b0;
      r_weight <= '0;
      // NOTE: the window is a small register array, not a RAM, so clearing it on reset is cheap and deterministic.
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          r_win[r][c] <= '0;
        end
        r_row[r] <= '0;
      end
      r_v1      <= 1'b0;
      r_last1   <= 1'b0;
      r_v2      <= 1'b0;
      r_last2   <= 1'b0;
      sum_out   <= '0;
      bin_out   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (in_valid) begin
        if (w_first) begin
          r_mode   <= state;
          r_weight <= weight;
        end
        r_k <= w_last_k ? 10'd0 : r_k + 10'd1;
        r_x <= (w_last_k || (r_x == w_last_x)) ? 5'd0 : r_x + 5'd1;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
          r_win[r][4] <= taps[(4-r)*DW +: DW];
        end
      end

      // Stage 1 valid: only words that complete a full 5-column window within one row.
      r_v1    <= in_valid && (r_x >= 5'd4);
      r_last1 <= in_valid && w_last_k;

      for (int r = 0; r < 5; r++) begin
        r_row[r] <= w_row_sum[r];
      end
      r_v2    <= r_v1;
      r_last2 <= r_last1;

      out_valid <= r_v2;
      done      <= r_v2 && r_last2;
      if (r_v2) begin
        sum_out <= w_total;
        bin_out <= ~w_total[AW-1];
      end
    end
  end

endmodule

// File: tb/tb_conv5x5_bin.sv
// Directed bench for conv5x5_bin: uniform frames with hand-computed sums, an
// independent convolution model for mixed data, gap tolerance and mid-frame reset.
`timescale 1ns/1ps
module tb_conv5x5_bin;

  localparam int DW = 16;
  localparam int AW = 21;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 state;
  logic [5*DW-1:0]      taps;
  logic [24:0]          weight;
  logic signed [AW-1:0] sum_out;
  logic                 bin_out;
  logic                 out_valid;
  logic                 done;

  conv5x5_bin #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .state     (state),
    .taps      (taps),
    .weight    (weight),
    .sum_out   (sum_out),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    logic   bin;
    logic   dn;
    int     cyc;
  } res_t;

  int     cyc = 0;
  res_t   q[$];
  int     orphan_done = 0;
  int     n_checks = 0;
  int     n_errors = 0;

  logic signed [DW-1:0] pix [672][5];
  longint exp_q[$];
  longint gapless_q[$];
  int     drive4_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples on the falling edge, half a period away from updates.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q.push_back('{longint'(sum_out), bin_out, done, cyc});
    end else if (done !== 1'b0) begin
      orphan_done++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic put_word(input int k);
    for (int r = 0; r < 5; r++) taps[(4-r)*DW +: DW] = pix[k][r];
  endtask

  task automatic rand_taps();
    taps = {$urandom(), $urandom(), 16'($urandom())};
  endtask

  task automatic fill_const(input logic signed [DW-1:0] v);
    for (int k = 0; k < 672; k++)
      for (int r = 0; r < 5; r++) pix[k][r] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 672; k++)
      for (int r = 0; r < 5; r++) pix[k][r] = DW'($urandom());
  endtask

  task automatic drain();
    step();
    in_valid = 1'b0;
    rand_taps();
    repeat (6) step();
  endtask

  // Drives one frame; with toggle set, state and weight inputs change after the first word.
  task automatic run_frame(input bit mode, input logic [24:0] w, input bit gaps, input bit toggle);
    int nw;
    nw = mode ? 96 : 672;
    for (int k = 0; k < nw; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 99) < 30) begin
          step();
          in_valid = 1'b0;
          rand_taps();
        end
      end
      step();
      in_valid = 1'b1;
      put_word(k);
      state  = (toggle && k >= nw / 2) ? ~mode : mode;
      weight = (toggle && k >= 1) ? ~w : w;
      if (k == 4) drive4_cyc = cyc;
    end
    drain();
  endtask

  // Direct convolution over stored columns: result for word k uses words k-4..k.
  task automatic build_model(input bit mode, input logic [24:0] w);
    int wd;
    longint s, p;
    wd = mode ? 12 : 28;
    exp_q.delete();
    for (int k = 0; k < wd * (wd - 4); k++) begin
      if (k % wd >= 4) begin
        s = 0;
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++) begin
            p = longint'(pix[k-4+c][r]);
            s = w[r*5+c] ? s + p : s - p;
          end
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    int n, bad_sum, bad_bin, dones;
    logic last_dn;
    n = q.size() - base;
    bad_sum = 0;
    bad_bin = 0;
    dones = 0;
    last_dn = 1'b0;
    check({tag, " count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      if (q[base+i].sum != exp_q[i]) bad_sum++;
      if (q[base+i].bin !== (exp_q[i] >= 0)) bad_bin++;
    end
    for (int i = 0; i < n; i++) if (q[base+i].dn === 1'b1) dones++;
    if (n > 0) last_dn = q[base+n-1].dn;
    check({tag, " sum mismatches"}, bad_sum, 0);
    check({tag, " bin mismatches"}, bad_bin, 0);
    check({tag, " done count"}, dones, 1);
    check({tag, " done on last"}, longint'(last_dn), 1);
  endtask

  initial begin
    logic [24:0] w;
    int base;
    int bad;

    // Reset held two cycles with live input.
    rst = 1'b1;
    in_valid = 1'b1;
    state = 1'b0;
    weight = 25'($urandom());
    rand_taps();
    step();
    rand_taps();
    step();
    check("reset sum_out", longint'(sum_out), 0);
    check("reset bin_out", longint'(bin_out), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset done", longint'(done), 0);
    check("reset no pulses", q.size(), 0);
    rst = 1'b0;
    in_valid = 1'b0;

    // Mode 0, all ones, all +1 weights: every window sums to 25.
    fill_const(16'sd1);
    w = '1;
    base = q.size();
    run_frame(1'b0, w, 1'b0, 1'b0);
    build_model(1'b0, w);
    check_frame("m0 ones", base);
    check("m0 ones first sum", (q.size() > base) ? q[base].sum : 0, 25);
    check("m0 first latency", (q.size() > base) ? q[base].cyc - drive4_cyc : -1, 3);

    // Mode 1, all twos, all -1 weights: every window sums to -50.
    fill_const(16'sd2);
    w = '0;
    base = q.size();
    run_frame(1'b1, w, 1'b0, 1'b0);
    build_model(1'b1, w);
    check_frame("m1 twos", base);
    check("m1 twos first sum", (q.size() > base) ? q[base].sum : 0, -50);
    check("m1 twos first bin", (q.size() > base) ? longint'(q[base].bin) : 1, 0);

    // Extreme negative lanes: 25 * -32768 must not wrap.
    fill_const(-16'sd32768);
    w = '1;
    base = q.size();
    run_frame(1'b1, w, 1'b0, 1'b0);
    build_model(1'b1, w);
    check_frame("m1 min", base);
    check("m1 min first sum", (q.size() > base) ? q[base].sum : 0, -819200);

    // Checkerboard weights over random pixels.
    fill_rand();
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) w[r*5+c] = ((r + c) % 2 == 0);
    base = q.size();
    run_frame(1'b1, w, 1'b0, 1'b0);
    build_model(1'b1, w);
    check_frame("m1 checker", base);

    // Same random mode-0 frame gapless, then with ~30% idle cycles.
    fill_rand();
    w = 25'($urandom());
    base = q.size();
    run_frame(1'b0, w, 1'b0, 1'b0);
    build_model(1'b0, w);
    check_frame("m0 gapless", base);
    gapless_q.delete();
    for (int i = base; i < q.size(); i++) gapless_q.push_back(q[i].sum);
    base = q.size();
    run_frame(1'b0, w, 1'b1, 1'b0);
    check_frame("m0 gaps", base);
    bad = 0;
    for (int i = 0; i < gapless_q.size() && base + i < q.size(); i++)
      if (q[base+i].sum != gapless_q[i]) bad++;
    check("gaps vs gapless count", q.size() - base, gapless_q.size());
    check("gaps vs gapless diffs", bad, 0);

    // Reset at frame word 300 of a mode-0 frame.
    fill_rand();
    w = 25'($urandom());
    for (int k = 0; k < 300; k++) begin
      step();
      in_valid = 1'b1;
      put_word(k);
      state = 1'b0;
      weight = w;
    end
    step();
    rst = 1'b1;
    in_valid = 1'b1;
    rand_taps();
    base = q.size();
    step();
    rand_taps();
    step();
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset sum_out", longint'(sum_out), 0);
    rst = 1'b0;
    in_valid = 1'b0;

    // New mode-1 frame with state and weight inputs changing mid-frame.
    fill_rand();
    w = 25'($urandom());
    run_frame(1'b1, w, 1'b0, 1'b1);
    build_model(1'b1, w);
    check_frame("post-reset m1", base);

    check("orphan done pulses", orphan_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
